cpu_multicycle_core: RTL and testbench

//   Parametrised multi-cycle CPU: FETCH/DECODE/EXECUTE/MEM/WB state machine, internal register file, ALU.

---
 rtl/cpu_multicycle_core_if.sv | 15 +
 rtl/cpu_multicycle_core.sv | 183 ++++++++++++++++++
 tb/tb_cpu_multicycle_core.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_multicycle_core_if.sv
// rtl/cpu_multicycle_core_if.sv - word-memory req/ack bus between the core and external memory
interface cpu_multicycle_core_if #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16
);
  logic [BITS_ADDR-1:0] MAR;
  logic [BITS_DATA-1:0] MBR_W;
  logic [BITS_DATA-1:0] MBR_R;
  logic                 write;
  logic                 mem_req;
  logic                 mem_ack;

  modport master (output MAR, MBR_W, write, mem_req, input MBR_R, mem_ack);
  modport slave  (input MAR, MBR_W, write, mem_req, output MBR_R, mem_ack);
endinterface

// File: rtl/cpu_multicycle_core.sv
// rtl/cpu_multicycle_core.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WB CPU with register file and ALU
// Optional multiplier (op 0x16) enabled by defining CPU_MUL_EN.
module cpu_multicycle_core #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16,
  parameter int NUM_REGS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_multicycle_core_if.master bus,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  retire,
  output logic                  halted,
  output logic                  illegal
);
  localparam int RI = $clog2(NUM_REGS);

  localparam logic [7:0] OP_NOP = 8'h00, OP_LDI = 8'h01, OP_MOV = 8'h02, OP_LD  = 8'h03,
                         OP_ST  = 8'h04, OP_ADD = 8'h10, OP_SUB = 8'h11, OP_AND = 8'h12,
                         OP_OR  = 8'h13, OP_XOR = 8'h14, OP_MUL = 8'h16, OP_BNE = 8'h20,
                         OP_JMP = 8'h21, OP_HLT = 8'hFF;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

  state_t               state, nextState;
  logic [31:0]          ir;
  logic [BITS_ADDR-1:0] pc;
  logic [BITS_DATA-1:0] regs [NUM_REGS];
  logic [BITS_DATA-1:0] opA, opB, opD, result;
  logic                 started;

  logic [7:0]           op;
  logic [RI-1:0]        rdIdx, raIdx, rbIdx;
  logic [15:0]          imm;
  logic [BITS_DATA-1:0] immExt;
  logic                 memDone;
  logic                 unusedIrBits;

  assign op           = ir[31:24];
  assign rdIdx        = ir[20 +: RI];
  assign raIdx        = ir[16 +: RI];
  assign rbIdx        = ir[12 +: RI];
  assign imm          = ir[15:0];
  assign immExt       = {{(BITS_DATA-16){1'b0}}, imm};
  assign memDone      = bus.mem_req && bus.mem_ack;
  assign unusedIrBits = ^ir;

  function automatic logic opLegal(input logic [7:0] o);
    case (o)
      OP_NOP, OP_LDI, OP_MOV, OP_LD, OP_ST, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR, OP_BNE, OP_JMP: opLegal = 1'b1;
`ifdef CPU_MUL_EN
      OP_MUL:                                opLegal = 1'b1;
`endif
      default:                               opLegal = 1'b0;
    endcase
  endfunction

  // ALU: carry is the unsigned carry-out for ADD and no-borrow for SUB
  logic [BITS_DATA:0]   sumExt, diffExt;
  logic [BITS_DATA-1:0] aluRes;
  logic                 aluCarry, aluValid;

  assign sumExt  = {1'b0, opA} + {1'b0, opB};
  assign diffExt = {1'b0, opA} - {1'b0, opB};

  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    aluValid = 1'b1;
    case (op)
      OP_ADD: begin aluRes = sumExt[BITS_DATA-1:0];  aluCarry = sumExt[BITS_DATA];   end
      OP_SUB: begin aluRes = diffExt[BITS_DATA-1:0]; aluCarry = !diffExt[BITS_DATA]; end
      OP_AND: aluRes = opA & opB;
      OP_OR:  aluRes = opA | opB;
      OP_XOR: aluRes = opA ^ opB;
`ifdef CPU_MUL_EN
      OP_MUL: aluRes = BITS_DATA'(opA * opB);
`endif
      default: aluValid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:   if (memDone) nextState = DECODE;
      DECODE:  nextState = (op == OP_HLT || !opLegal(op)) ? HALT : EXECUTE;
      EXECUTE: begin
        case (op)
          OP_LD, OP_ST:           nextState = MEM;
          OP_BNE, OP_JMP, OP_NOP: nextState = FETCH;
          default:                nextState = WB;
        endcase
      end
      MEM:     if (memDone) nextState = (op == OP_ST) ? FETCH : WB;
      WB:      nextState = FETCH;
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  // The first fetch after reset waits one cycle so every output stays 0 while reset is held
  always_comb begin
    bus.mem_req = 1'b0;
    bus.MAR     = '0;
    bus.write   = 1'b0;
    bus.MBR_W   = '0;
    retire      = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_req = started;
        bus.MAR     = pc;
      end
      EXECUTE: retire = (op == OP_BNE) || (op == OP_JMP) || (op == OP_NOP);
      MEM: begin
        bus.mem_req = 1'b1;
        bus.MAR     = imm[BITS_ADDR-1:0];
        bus.write   = (op == OP_ST);
        bus.MBR_W   = (op == OP_ST) ? opD : '0;
        retire      = memDone && (op == OP_ST);
      end
      WB:      retire = 1'b1;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // R0 is never written, so it keeps its reset value of 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      opA     <= '0;
      opB     <= '0;
      opD     <= '0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      illegal <= 1'b0;
      started <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        FETCH: if (memDone) begin
          ir <= bus.MBR_R[31:0];
          pc <= pc + BITS_ADDR'(1);
        end
        DECODE: begin
          opA <= regs[raIdx];
          opB <= regs[rbIdx];
          opD <= regs[rdIdx];
          if (op != OP_HLT && !opLegal(op)) illegal <= 1'b1;
        end
        EXECUTE: begin
          if (aluValid) begin
            result <= aluRes;
            flag_c <= aluCarry;
            flag_z <= (aluRes == '0);
          end
          case (op)
            OP_LDI: result <= immExt;
            OP_MOV: result <= opA;
            OP_BNE: if (opD != opA) pc <= imm[BITS_ADDR-1:0];
            OP_JMP: pc <= imm[BITS_ADDR-1:0];
            default: ;
          endcase
        end
        MEM: if (memDone && op == OP_LD) result <= bus.MBR_R;
        WB:  if (rdIdx != '0) regs[rdIdx] <= result;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_multicycle_core.sv
// tb/tb_cpu_multicycle_core.sv - scoreboard bench for cpu_multicycle_core with a wait-state memory model
module tb_cpu_multicycle_core;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flag_c, flag_z, retire, halted, illegal;

  cpu_multicycle_core_if #(.BITS_DATA(32), .BITS_ADDR(16)) bus ();

  cpu_multicycle_core #(.BITS_DATA(32), .BITS_ADDR(16), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .flag_c(flag_c), .flag_z(flag_z), .retire(retire), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("FAIL %s: unexpected event", name);
  endtask

  // Memory: reloaded from image while reset is held, ack after ackDelay wait states
  logic [31:0] image [256];
  logic [31:0] mem   [256];
  int ackDelay = 0;
  int waitCnt  = 0;

  assign bus.mem_ack = bus.mem_req && (waitCnt >= ackDelay);
  assign bus.MBR_R   = mem[bus.MAR[7:0]];

  always @(posedge clk) begin
    if (reset) begin
      waitCnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else if (!bus.mem_req || bus.mem_ack) begin
      waitCnt <= 0;
      if (bus.mem_ack && bus.write) mem[bus.MAR[7:0]] <= bus.MBR_W;
    end else begin
      waitCnt <= waitCnt + 1;
    end
  end

  logic [1:0]  flagQ  [$];
  logic [47:0] storeQ [$];
  logic        haltQ  [$];

  task automatic expF(input int n, input logic c, input logic z);
    for (int i = 0; i < n; i++) flagQ.push_back({c, z});
  endtask
  task automatic expS(input logic [15:0] a, input logic [31:0] d);
    storeQ.push_back({a, d});
  endtask

  // Monitor: pops expectations as the DUT retires, stores or halts
  logic        waiting = 1'b0;
  logic        prevHalted = 1'b0;
  logic [48:0] holdBus;
  always @(negedge clk) begin
    if (reset) begin
      waiting    = 1'b0;
      prevHalted = 1'b0;
    end else begin
      if (waiting && bus.mem_req) check("bus_stable", {bus.write, bus.MAR, bus.MBR_W}, holdBus);
      waiting = bus.mem_req && !bus.mem_ack;
      holdBus = {bus.write, bus.MAR, bus.MBR_W};
      if (retire) begin
        if (flagQ.size() == 0) failNow("extra_retire");
        else check("retire_flags", {flag_c, flag_z}, flagQ.pop_front());
      end
      if (bus.mem_req && bus.mem_ack && bus.write) begin
        if (storeQ.size() == 0) failNow("extra_store");
        else check("store", {bus.MAR, bus.MBR_W}, storeQ.pop_front());
      end
      if (halted && !prevHalted) begin
        if (haltQ.size() == 0) failNow("extra_halt");
        else check("halt_illegal", illegal, haltQ.pop_front());
      end
      if (halted) check("halt_no_req", bus.mem_req, 0);
      prevHalted = halted;
    end
  end

  task automatic clearImage();
    for (int i = 0; i < 256; i++) image[i] = 32'h0;
  endtask

  task automatic loadP1();
    clearImage();
    image[0] = 32'h01100005;  // LDI R1,5
    image[1] = 32'h01200007;  // LDI R2,7
    image[2] = 32'h10312000;  // ADD R3,R1,R2
    image[3] = 32'h04300040;  // ST R3 -> 0x40
    image[4] = 32'hFF000000;  // HLT
  endtask

  task automatic drained(input string tag);
    check({tag, "_flagq_left"}, flagQ.size(), 0);
    check({tag, "_storeq_left"}, storeQ.size(), 0);
    check({tag, "_haltq_left"}, haltQ.size(), 0);
  endtask

  task automatic runProg(input int delay, input int expCycles, input string tag);
    int n;
    ackDelay = delay;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!halted && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_halted"}, halted, 1);
    if (expCycles > 0) check({tag, "_cycles"}, n, expCycles);
    repeat (8) @(negedge clk);
    drained(tag);
  endtask

  initial begin
    int n;
    loadP1();
    @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_write", bus.write, 0);
    check("rst_mar", bus.MAR, 0);
    check("rst_mbr_w", bus.MBR_W, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_flags", {flag_c, flag_z}, 0);

    // Basic program, zero wait then 3 wait states per request
    expF(4, 0, 0); expS(16'h40, 32'd12); haltQ.push_back(1'b0);
    runProg(0, 19, "p1");
    loadP1();
    expF(4, 0, 0); expS(16'h40, 32'd12); haltQ.push_back(1'b0);
    runProg(3, 37, "p1_wait");

    // Flag behaviour for SUB/ADD/XOR/OR
    clearImage();
    image[0]  = 32'h0110FFFF;  // LDI R1,0xFFFF
    image[1]  = 32'h01200001;  // LDI R2,1
    image[2]  = 32'h11321000;  // SUB R3,R2,R1
    image[3]  = 32'h11411000;  // SUB R4,R1,R1
    image[4]  = 32'h10533000;  // ADD R5,R3,R3
    image[5]  = 32'h14611000;  // XOR R6,R1,R1
    image[6]  = 32'h04300041;
    image[7]  = 32'h04400042;
    image[8]  = 32'h04500043;
    image[9]  = 32'h13731000;  // OR R7,R3,R1
    image[10] = 32'h04700044;
    image[11] = 32'hFF000000;
    expF(3, 0, 0); expF(1, 1, 1); expF(1, 1, 0); expF(4, 0, 1); expF(2, 0, 0);
    expS(16'h41, 32'hFFFF0002); expS(16'h42, 32'h0); expS(16'h43, 32'hFFFE0004);
    expS(16'h44, 32'hFFFFFFFF); haltQ.push_back(1'b0);
    runProg(1, 0, "p2");

    // Countdown loop, JMP over an illegal word, LD back a stored value
    clearImage();
    image[0]  = 32'h01100003;  // LDI R1,3
    image[1]  = 32'h01200001;  // LDI R2,1
    image[2]  = 32'h10442000;  // ADD R4,R4,R2
    image[3]  = 32'h11112000;  // SUB R1,R1,R2
    image[4]  = 32'h20100002;  // BNE R1,R0 -> 2
    image[5]  = 32'h04400050;
    image[6]  = 32'h04100051;
    image[7]  = 32'h21000009;  // JMP 9
    image[8]  = 32'h05000000;
    image[9]  = 32'h03600050;  // LD R6,M[0x50]
    image[10] = 32'h04600052;
    image[11] = 32'hFF000000;
    expF(2, 0, 0);
    for (int i = 0; i < 2; i++) begin expF(1, 0, 0); expF(2, 1, 0); end
    expF(1, 0, 0); expF(2, 1, 1);
    expF(5, 1, 1);
    expS(16'h50, 32'd3); expS(16'h51, 32'd0); expS(16'h52, 32'd3); haltQ.push_back(1'b0);
    runProg(2, 0, "p3");

    // R0 write ignored, op 0x16
    clearImage();
    image[0] = 32'h01001234;  // LDI R0,0x1234
    image[1] = 32'h04000060;
    image[2] = 32'h01100006;
    image[3] = 32'h01200007;
    image[4] = 32'h16312000;  // MUL R3,R1,R2
    image[5] = 32'h04300061;
    image[6] = 32'hFF000000;
    expS(16'h60, 32'd0);
`ifdef CPU_MUL_EN
    expF(6, 0, 0); expS(16'h61, 32'd42); haltQ.push_back(1'b0);
`else
    expF(4, 0, 0); haltQ.push_back(1'b1);
`endif
    runProg(0, 0, "p4");

    // AND, MOV, NOP then an undefined opcode
    clearImage();
    image[0] = 32'h01100F0F;
    image[1] = 32'h012000FF;
    image[2] = 32'h12312000;  // AND R3,R1,R2
    image[3] = 32'h12410000;  // AND R4,R1,R0
    image[4] = 32'h02530000;  // MOV R5,R3
    image[5] = 32'h04500070;
    image[6] = 32'h00000000;
    image[7] = 32'h05000000;
    expF(3, 0, 0); expF(4, 0, 1); expS(16'h70, 32'h0000000F); haltQ.push_back(1'b1);
    runProg(0, 0, "p5");

    // Reset while a store waits for ack, then rerun from PC 0
    loadP1();
    expF(3, 0, 0);
    expF(4, 0, 0); expS(16'h40, 32'd12); haltQ.push_back(1'b0);
    ackDelay = 5;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.write) && n < 300) begin @(negedge clk); n++; end
    check("st_req_seen", bus.mem_req && bus.write, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_drops_req", bus.mem_req, 0);
    check("rst_drops_write", bus.write, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    check("refetch_req", bus.mem_req, 1);
    check("refetch_pc0", bus.MAR, 0);
    n = 0;
    while (!halted && n < 500) begin @(posedge clk); #1; n++; end
    check("rerun_halted", halted, 1);
    repeat (4) @(negedge clk);
    drained("rerun");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
